// File: rtl/systolic_result_drain_pkg.sv
// Shared types and helpers for the systolic result drain.
package systolic_result_drain_pkg;

  localparam int DEF_N          = 8;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_RUN  = 2'd1,
    DRAIN_DONE = 2'd2
  } drain_state_e;

  // Counter/pointer width; a single-entry structure still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_result_drain_fifo.sv
// Per-column result FIFO: one push and one pop per cycle, no write-to-read bypass.
module systolic_result_drain_fifo
  import systolic_result_drain_pkg::*;
#(
  parameter int DEPTH      = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PW = cnt_width(DEPTH);
  localparam int OW = cnt_width(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_q, rd_q;
  logic [OW-1:0]         cnt_q;
  logic                  do_push_s, do_pop_s;

  assign full_o    = (cnt_q == OW'(DEPTH));
  assign empty_o   = (cnt_q == OW'(0));
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign data_o    = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push_s) begin
        wr_q <= (wr_q == LAST_PTR) ? '0 : wr_q + PW'(1);
      end
      if (do_pop_s) begin
        rd_q <= (rd_q == LAST_PTR) ? '0 : rd_q + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + OW'(1);
        2'b01:   cnt_q <= cnt_q - OW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Collects south-edge results per column and re-emits them as a row-major stream.
// Optional DRAIN_OUT_REG_EN: outputs come from a 2-entry skid register stage.
module systolic_result_drain
  import systolic_result_drain_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [N*DATA_WIDTH-1:0] south_i,
  input  logic [N-1:0]            south_valid_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [cnt_width(N)-1:0] row_o,
  output logic [cnt_width(N)-1:0] col_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overflow_o
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef logic [DATA_WIDTH-1:0] data_t;

  drain_state_e  state_q;
  logic [CW-1:0] row_q, col_q;
  logic          overflow_q, busy_q, done_q;

  logic          run_s, clear_s;
  logic          issue_valid_s, issue_fire_s, issue_last_s, last_acc_s;
  logic [N-1:0]  push_s, pop_s, full_s, empty_s;
  data_t         head_s [N];

  assign run_s        = (state_q == DRAIN_RUN);
  assign clear_s      = (state_q == DRAIN_IDLE) && start_i;
  assign push_s       = run_s ? south_valid_i : '0;
  assign issue_last_s = (row_q == LAST_IDX) && (col_q == LAST_IDX);

  for (genvar c = 0; c < N; c++) begin : g_col
    systolic_result_drain_fifo #(
      .DEPTH      (N),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_s),
      .push_i  (push_s[c]),
      .data_i  (south_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .pop_i   (pop_s[c]),
      .data_o  (head_s[c]),
      .full_o  (full_s[c]),
      .empty_o (empty_s[c])
    );
  end

  // Only the column under the col counter is ever popped.
  always_comb begin
    pop_s = '0;
    if (issue_fire_s) begin
      pop_s[col_q] = 1'b1;
    end else begin
      pop_s = '0;
    end
  end

`ifdef DRAIN_OUT_REG_EN
  logic          issued_all_q;
  logic          out_v_q, out_last_q, skid_v_q, skid_last_q;
  data_t         out_data_q, skid_data_q;
  logic [CW-1:0] out_row_q, out_col_q, skid_row_q, skid_col_q;

  // Issue depends only on registered skid occupancy, never on ready_i.
  assign issue_valid_s = run_s && !issued_all_q && !empty_s[col_q];
  assign issue_fire_s  = issue_valid_s && !skid_v_q;
  assign last_acc_s    = out_v_q && ready_i && out_last_q;

  // Output register backed by one skid entry that absorbs the beat issued during a stall.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_s) begin
      issued_all_q <= 1'b0;
      out_v_q      <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      skid_v_q     <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_row_q   <= '0;
      skid_col_q   <= '0;
    end else begin
      if (issue_fire_s && issue_last_s) begin
        issued_all_q <= 1'b1;
      end
      if (!out_v_q || ready_i) begin
        if (skid_v_q) begin
          out_v_q    <= 1'b1;
          out_last_q <= skid_last_q;
          out_data_q <= skid_data_q;
          out_row_q  <= skid_row_q;
          out_col_q  <= skid_col_q;
          skid_v_q   <= 1'b0;
        end else begin
          out_v_q    <= issue_fire_s;
          out_last_q <= issue_fire_s && issue_last_s;
          out_data_q <= issue_fire_s ? head_s[col_q] : '0;
          out_row_q  <= row_q;
          out_col_q  <= col_q;
        end
      end else if (issue_fire_s) begin
        skid_v_q    <= 1'b1;
        skid_last_q <= issue_last_s;
        skid_data_q <= head_s[col_q];
        skid_row_q  <= row_q;
        skid_col_q  <= col_q;
      end
    end
  end

  assign valid_o = out_v_q;
  assign data_o  = out_data_q;
  assign row_o   = out_row_q;
  assign col_o   = out_col_q;
  assign last_o  = out_v_q && out_last_q;
`else
  assign issue_valid_s = run_s && !empty_s[col_q];
  assign issue_fire_s  = issue_valid_s && ready_i;
  assign last_acc_s    = issue_fire_s && issue_last_s;

  assign valid_o = issue_valid_s;
  assign data_o  = issue_valid_s ? head_s[col_q] : '0;
  assign row_o   = row_q;
  assign col_o   = col_q;
  assign last_o  = issue_valid_s && issue_last_s;
`endif

  // Pass FSM with coordinate counters and registered status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= DRAIN_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        DRAIN_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q    <= DRAIN_RUN;
            row_q      <= '0;
            col_q      <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        DRAIN_RUN: begin
          if (|(push_s & full_s)) begin
            overflow_q <= 1'b1;
          end
          if (issue_fire_s) begin
            if (col_q == LAST_IDX) begin
              col_q <= '0;
              row_q <= (row_q == LAST_IDX) ? '0 : row_q + CW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
          if (last_acc_s) begin
            state_q <= DRAIN_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DRAIN_DONE: begin
          state_q <= DRAIN_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= DRAIN_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized bench for systolic_result_drain (N=4) against a queue-based pass model.
module tb_systolic_result_drain;

  localparam int N  = 4;
  localparam int DW = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [N*DW-1:0]   south_i;
  logic [N-1:0]      south_valid_i;
  logic [DW-1:0]     data_o;
  logic [1:0]        row_o, col_o;
  logic              valid_o, ready_i, last_o, busy_o, done_o, overflow_o;

  systolic_result_drain #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .south_i       (south_i),
    .south_valid_i (south_valid_i),
    .data_o        (data_o),
    .row_o         (row_o),
    .col_o         (col_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .last_o        (last_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of one pass: per-column queues of captured words plus a beat index.
  logic [DW-1:0] mq [N][$];
  bit            m_run, m_done, m_ovf;
  int            m_beat;

  int            sched_t [N][N+1];
  logic [DW-1:0] sched_v [N][N+1];
  int            n_words [N];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < N; c++) mq[c].delete();
    m_beat = 0;
  endtask

  // Compare this cycle's outputs to the model, then advance the model across the edge.
  task automatic step();
    bit ev, acc;
    int mc, mr;
    #1;
    mc = m_beat % N;
    mr = m_beat / N;
    ev = m_run && (mq[mc].size() > 0);
    check_eq("valid", {31'd0, valid_o}, {31'd0, ev});
    if (ev) begin
      check_eq("data", data_o, mq[mc][0]);
      check_eq("row", {30'd0, row_o}, mr);
      check_eq("col", {30'd0, col_o}, mc);
      check_eq("last", {31'd0, last_o}, {31'd0, (m_beat == N*N-1)});
    end else begin
      check_eq("last_idle", {31'd0, last_o}, 32'd0);
    end
    check_eq("done", {31'd0, done_o}, {31'd0, m_done});
    check_eq("busy", {31'd0, busy_o}, {31'd0, m_run});
    check_eq("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
    acc = ev && ready_i;
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_run) begin
      for (int c = 0; c < N; c++) begin
        if (south_valid_i[c]) begin
          if (mq[c].size() < N) mq[c].push_back(south_i[c*DW +: DW]);
          else m_ovf = 1'b1;
        end
      end
      if (acc) begin
        void'(mq[mc].pop_front());
        m_beat++;
        if (m_beat == N*N) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (start_i) begin
      m_run = 1'b1;
      m_ovf = 1'b0;
      model_clear();
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    start_i = 1'b0;
    ready_i = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      south_valid_i = N'($urandom);
      south_i       = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
      check_eq("rst_data", data_o, 32'd0);
      check_eq("rst_rowcol", {28'd0, row_o, col_o}, 32'd0);
      check_eq("rst_flags", {28'd0, last_o, busy_o, done_o, overflow_o}, 32'd0);
    end
    rst_i  = 1'b0;
    m_run  = 1'b0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
    model_clear();
    step();
    south_valid_i = '0;
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 stalled for the first 12 cycles.
  // sched_mode: 0 skewed by column, 1 column 0 late by 10, 2 random gaps.
  task automatic run_pass(input int rdy_mode, input int sched_mode, input bit extra2,
                          input int abort_at, input bit noise, input bit seq_vals);
    int  idx [N];
    int  t;
    bit  pass_end;
    for (int c = 0; c < N; c++) begin
      idx[c]     = 0;
      n_words[c] = (extra2 && c == 2) ? N + 1 : N;
      for (int r = 0; r <= N; r++) begin
        case (sched_mode)
          0:       sched_t[c][r] = r + c;
          1:       sched_t[c][r] = (c == 0) ? r + 10 : r;
          default: sched_t[c][r] = (r == 0) ? int'($urandom_range(0, 3))
                                            : sched_t[c][r-1] + int'($urandom_range(0, 3));
        endcase
        if (extra2 && c == 2) sched_t[c][r] = r;
        sched_v[c][r] = seq_vals ? 32'(16*r + c) : $urandom;
      end
    end
    start_i       = 1'b1;
    south_valid_i = '0;
    ready_i       = 1'b1;
    step();
    start_i  = 1'b0;
    t        = 0;
    pass_end = 1'b0;
    while (!pass_end && t < 300) begin
      if (abort_at >= 0 && m_beat == abort_at) begin
        do_reset();
        return;
      end
      for (int c = 0; c < N; c++) begin
        if (idx[c] < n_words[c] && sched_t[c][idx[c]] <= t) begin
          south_valid_i[c]      = 1'b1;
          south_i[c*DW +: DW]   = sched_v[c][idx[c]];
          idx[c]++;
        end else begin
          south_valid_i[c]      = 1'b0;
          south_i[c*DW +: DW]   = $urandom;
        end
      end
      case (rdy_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = 1'($urandom);
        default: ready_i = (t >= 12);
      endcase
      start_i = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (m_done) pass_end = 1'b1;
      if (extra2 && t == 8) check_eq("ovf_set", {31'd0, overflow_o}, 32'd1);
      step();
      t++;
    end
    check_eq("pass_timeout", {31'd0, pass_end}, 32'd1);
    start_i       = 1'b0;
    south_valid_i = '0;
    for (int i = 0; i < 2; i++) step();
  endtask

  initial begin
    rst_i         = 1'b1;
    start_i       = 1'b0;
    ready_i       = 1'b0;
    south_i       = '0;
    south_valid_i = '0;
    do_reset();
    run_pass(0, 0, 1'b0, -1, 1'b0, 1'b1);
    run_pass(1, 0, 1'b0, -1, 1'b0, 1'b1);
    run_pass(2, 0, 1'b1, -1, 1'b0, 1'b0);
    run_pass(0, 0, 1'b0, -1, 1'b0, 1'b0);
    run_pass(1, 1, 1'b0, -1, 1'b0, 1'b0);
    run_pass(0, 0, 1'b0,  7, 1'b0, 1'b1);
    run_pass(1, 0, 1'b0, -1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) run_pass(1, 2, 1'b0, -1, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
